// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, response and ALU-side signal bundle for alu_arbiter
interface alu_arbiter_if;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic        rsp0_valid, rsp0_ready;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp_c;
  logic        rsp_zero, rsp_negative;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_c;
  logic        alu_is_zero, alu_is_negative;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    input  alu_c, alu_is_zero, alu_is_negative,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_c, rsp_zero, rsp_negative,
    output alu_a, alu_b, alu_op, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    output alu_c, alu_is_zero, alu_is_negative,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_c, rsp_zero, rsp_negative,
    input  alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters (IDLE/EXEC/RESP)
// ALU_ARB_RR_EN selects round-robin tie-break; undefined gives fixed priority to port 0.
module alu_arbiter #(
  parameter int unsigned MUL_WAIT = 2
) (
  input logic        clk,
  input logic        reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] MulWaitC = 4'(MUL_WAIT);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] rsp_c_q, rsp_c_d;
  logic        zero_q, zero_d, neg_q, neg_d;
  logic        pick;
  logic [3:0]  sel_op;

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
      pick = ~last_grant_q;
`else
      pick = 1'b0;
`endif
    end else begin
      pick = bus.req1_valid;
    end
  end

  assign sel_op = pick ? bus.req1_op : bus.req0_op;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    rsp_c_d        = rsp_c_q;
    zero_d         = zero_q;
    neg_d          = neg_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((bus.req0_valid || bus.req1_valid) && !reset) begin
          bus.req0_ready = ~pick;
          bus.req1_ready = pick;
          grant_d  = pick;
          alu_a_d  = pick ? bus.req1_a : bus.req0_a;
          alu_b_d  = pick ? bus.req1_b : bus.req0_b;
          alu_op_d = sel_op;
          // Only MULLO/MULHI need extra settle time on the shared ALU.
          cnt_d    = (sel_op[3:1] == 3'b111) ? MulWaitC : 4'd0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_c_d = bus.alu_c;
          zero_d  = bus.alu_is_zero;
          neg_d   = bus.alu_is_negative;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        bus.rsp0_valid = ~grant_q;
        bus.rsp1_valid = grant_q;
        if (grant_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_op_q     <= 4'd0;
      rsp_c_q      <= 32'd0;
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_c_q      <= rsp_c_d;
      zero_q       <= zero_d;
      neg_q        <= neg_d;
    end
  end

  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.rsp_c        = rsp_c_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_negative = neg_q;
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  localparam int MW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hs_cyc = 0;

  typedef struct {
    logic        port;
    logic [31:0] c;
    logic        z;
    logic        n;
    int          lat;
  } exp_t;
  exp_t sb[$];

  alu_arbiter_if bus();
  alu_arbiter #(.MUL_WAIT(MW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    logic        found;
    p = {32'd0, a} * {32'd0, b};
    r = a;
    found = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~a;
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'hFFFF_FFFF : ((a == b) ? 32'd0 : 32'd1);
      4'd9:  r = a & b;
      4'd10: begin
        r = 32'd32;
        for (int i = 31; i >= 0; i--) if (a[i] && !found) begin r = 32'(31 - i); found = 1'b1; end
      end
      4'd12: r = a << b[4:0];
      4'd13: r = a >> b[4:0];
      4'd14: r = p[31:0];
      4'd15: r = p[63:32];
      default: r = a;
    endcase
    return r;
  endfunction

  assign bus.alu_c           = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_is_zero     = (bus.alu_c == 32'd0);
  assign bus.alu_is_negative = bus.alu_c[31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rspv(input logic p);
    return p ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  function automatic exp_t mk(input logic p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.port = p;
    e.c    = alu_f(op, a, b);
    e.z    = (e.c == 32'd0);
    e.n    = e.c[31];
    e.lat  = (op[3:1] == 3'b111) ? 2 + MW : 2;
    return e;
  endfunction

  task automatic set_req(input logic p, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p) begin bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; end
    else   begin bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; end
  endtask

  task automatic send(input logic p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    @(negedge clk);
    set_req(p, 1'b1, op, a, b);
    #1;
    guard = 0;
    while (!(p ? bus.req1_ready : bus.req0_ready) && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    chk("req_ready", 32'(p ? bus.req1_ready : bus.req0_ready), 32'd1);
    hs_cyc = cyc;
    sb.push_back(mk(p, op, a, b));
    @(posedge clk); #1;
    set_req(p, 1'b0, op, a, b);
  endtask

  task automatic recv(input int hold);
    exp_t e;
    int   guard;
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    @(negedge clk);
    guard = 0;
    while (!rspv(e.port) && guard < 40) begin @(negedge clk); guard++; end
    chk("rsp_valid", 32'(rspv(e.port)), 32'd1);
    chk("rsp_other", 32'(rspv(~e.port)), 32'd0);
    chk("rsp_latency", 32'(cyc - hs_cyc), 32'(e.lat));
    chk("rsp_c", bus.rsp_c, e.c);
    chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.z));
    chk("rsp_neg", 32'(bus.rsp_negative), 32'(e.n));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rspv(e.port)), 32'd1);
      chk("hold_c", bus.rsp_c, e.c);
      chk("hold_neg", 32'(bus.rsp_negative), 32'(e.n));
      chk("hold_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      chk("hold_busy", 32'(bus.busy), 32'd1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (e.port) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
    @(negedge clk);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_valid", 32'(rspv(e.port)), 32'd0);
    chk("post_c_kept", bus.rsp_c, e.c);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int   exp_g[4];
    int   ng, last, guard, g, idx;
    exp_t e;
    logic [31:0] tv[3];
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    tv = '{32'h1234_5678, 32'h0000_0000, 32'h8000_0000};
    set_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    do_reset();

    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_rsp_c", bus.rsp_c, 32'd0);
    chk("rst_flags", {30'd0, bus.rsp_zero, bus.rsp_negative}, 32'd0);
    chk("rst_valids", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);

    // ADD wrapping to zero on port 0
    send(1'b0, 4'd0, 32'h0000_0001, 32'hFFFF_FFFF);
    recv(0);
    chk("add_c", bus.rsp_c, 32'h0000_0000);
    chk("add_zero", 32'(bus.rsp_zero), 32'd1);

    // MULLO on port 1 with settle cycles
    send(1'b1, 4'd14, 32'd3, 32'd5);
    for (int i = 0; i < 1 + MW; i++) begin
      @(negedge clk);
      chk("mul_alu_op", 32'(bus.alu_op), 32'd14);
      chk("mul_no_rsp", 32'(bus.rsp1_valid), 32'd0);
    end
    recv(0);
    chk("mul_c", bus.rsp_c, 32'h0000_000F);

    // CMP held in RESP while the other port is requesting
    send(1'b0, 4'd8, 32'h8000_0000, 32'h0000_0001);
    set_req(1'b1, 1'b1, 4'd0, 32'd7, 32'd7);
    recv(5);
    chk("cmp_c", bus.rsp_c, 32'hFFFF_FFFF);
    chk("cmp_neg", 32'(bus.rsp_negative), 32'd1);

    // reset while MULHI is executing
    send(1'b0, 4'd15, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    chk("mulhi_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_alu_a", bus.alu_a, 32'd0);
    chk("abort_alu_b", bus.alu_b, 32'd0);
    chk("abort_alu_op", 32'(bus.alu_op), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    end
    set_req(1'b0, 1'b1, 4'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    set_req(1'b1, 1'b1, 4'd5, 32'h1, 32'h2);
    #1;
    chk("tie_ready0", 32'(bus.req0_ready), 32'd1);
    chk("tie_ready1", 32'(bus.req1_ready), 32'd0);
    hs_cyc = cyc;
    sb.push_back(mk(1'b0, 4'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0));
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    recv(0);

    // both ports continuously valid with SUB, responses taken at once
    do_reset();
    set_req(1'b0, 1'b1, 4'd1, 32'd100, 32'd1);
    set_req(1'b1, 1'b1, 4'd1, 32'd200, 32'd3);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    ng = 0; last = 0; guard = 0;
    while ((ng < 4 || sb.size() > 0) && guard < 60) begin
      @(negedge clk); guard++;
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        chk("rr_sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rr_rsp_port", 32'(bus.rsp1_valid), 32'(e.port));
          chk("rr_rsp_c", bus.rsp_c, e.c);
        end
      end
      if (bus.req0_ready || bus.req1_ready) begin
        g = int'(bus.req1_ready);
        chk("rr_grant", 32'(g), 32'(exp_g[ng]));
        if (ng > 0) chk("rr_interval", 32'(cyc - last), 32'd3);
        last = cyc;
        sb.push_back(g ? mk(1'b1, 4'd1, 32'd200, 32'd3) : mk(1'b0, 4'd1, 32'd100, 32'd1));
        ng++;
        if (ng == 4) begin
          @(posedge clk); #1;
          bus.req0_valid = 1'b0;
          bus.req1_valid = 1'b0;
        end
      end
    end
    chk("rr_grants", 32'(ng), 32'd4);
    bus.rsp1_ready = 1'b0;

    // back-to-back TEST on port 0
    idx = 0; last = 0; guard = 0; ng = 0;
    sb.delete();
    set_req(1'b0, 1'b1, 4'd9, tv[0], 32'hFFFF_FFFF);
    while (ng < 3 && guard < 40) begin
      @(negedge clk); guard++;
      if (bus.rsp0_valid) begin
        chk("b2b_sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("b2b_c", bus.rsp_c, tv[ng]);
          chk("b2b_zero", 32'(bus.rsp_zero), 32'(tv[ng] == 32'd0));
          chk("b2b_c_model", bus.rsp_c, e.c);
        end
        ng++;
      end
      if (bus.req0_ready && idx < 3) begin
        if (idx > 0) chk("b2b_interval", 32'(cyc - last), 32'd3);
        last = cyc;
        sb.push_back(mk(1'b0, 4'd9, tv[idx], 32'hFFFF_FFFF));
        idx++;
        @(posedge clk); #1;
        if (idx < 3) set_req(1'b0, 1'b1, 4'd9, tv[idx], 32'hFFFF_FFFF);
        else bus.req0_valid = 1'b0;
      end
    end
    chk("b2b_count", 32'(ng), 32'd3);
    bus.rsp0_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer that shares one combinational 32-bit ALU between two requesters (CPU execute stage on port 0, coprocessor/DMA on port 1). It accepts one operation at a time over a valid/ready handshake, holds the operands stable on the ALU inputs for the required number of cycles, and captures the result and flags. It then returns them to the granted requester over a response handshake. Multiply opcodes get extra settle cycles.

## Interface
- MUL_WAIT, 2, extra ALU settle cycles for MULLO/MULHI (op 14/15); legal range 0..15
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_op / req1_op  in  4  ALU opcode (0 ADD, 1 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 CMP, 9 TEST, 10 CLZ, 12 SHL, 13 SHR, 14 MULLO, 15 MULHI)
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp_c  out  32  captured result, shared by both response ports
- rsp_zero, rsp_negative  out  1  captured is_zero / is_negative
- alu_a, alu_b  out  32  registered ALU operands
- alu_op  out  4  registered ALU opcode
- alu_c  in  32  ALU result
- alu_is_zero, alu_is_negative  in  1  ALU flags
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: reqN_ready is combinational. It is 1 only for the requester chosen by arbitration among the current valids, and 0 for the other. On handshake, latch a/b/op into alu_a/alu_b/alu_op, latch grant id, and go to EXEC. If neither requester is valid, stay in IDLE.
- EXEC: load a counter with MUL_WAIT if op[3:1]==3'b111, else 0. Decrement the counter each cycle. When it is 0, capture alu_c/flags into rsp_c/rsp_zero/rsp_negative and go to RESP.
- RESP: assert rspN_valid for the granted requester only. rsp_c and the flags stay stable. On rspN_ready, go to IDLE and record the served id as last_grant.
- Both reqN_ready are 0 in EXEC and RESP. A request must hold valid and its payload until accepted.
- Opcodes 2, 3 and 11 are passed to the ALU unchanged. The arbiter has no opcode-specific behaviour other than the multiply wait.
- rsp_c and the flags keep their last value after the response handshake, until the next capture.
- Reset: state IDLE. All outputs are 0: ready, rsp_valid, rsp_c, flags, alu_a, alu_b, alu_op, busy. last_grant is set to 1, so port 0 wins the first tie. Reset asserted in any state discards the in-flight operation, and no response is ever delivered for it.

## Timing
- Request handshake in cycle n, non-multiply: rsp_valid high from cycle n+2.
- Multiply: rsp_valid high from cycle n+2+MUL_WAIT.
- alu_* change only on the handshake edge, so the ALU inputs stay stable for at least 1+MUL_WAIT cycles before capture.
- With rsp_ready tied high, the minimum issue interval is 3 cycles: IDLE, EXEC, RESP.
- The earliest new request acceptance is the cycle after the response handshake.
- busy rises the cycle after the request handshake and falls the cycle after the response handshake.

## Configuration
- ALU_ARB_RR_EN defined: round-robin. On a tie in IDLE, grant the port that is not last_grant. A single valid requester is always granted.
- ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins ties. last_grant is still updated but not used.

## Test plan
- req0 ADD a=0x00000001 b=0xFFFFFFFF, rsp0_ready=1 -> rsp0_valid in cycle n+2, rsp_c=0x00000000, rsp_zero=1, rsp_negative=0, rsp1_valid stays 0.
- req1 MULLO a=3 b=5 with MUL_WAIT=2 -> alu_op=14 stable for 3 cycles, rsp1_valid in cycle n+4, rsp_c=0x0000000F.
- Both ports continuously valid with SUB -> grants alternate 0,1,0,1 when ALU_ARB_RR_EN is defined; all grants go to port 0 when it is undefined.
- req0 CMP a=0x80000000 b=0x00000001 with rsp0_ready held low 5 cycles -> rsp0_valid, rsp_c=0xFFFFFFFF and rsp_negative=1 held stable, both req_ready 0, busy 1; after rsp0_ready is raised, return to IDLE next cycle.
- reset pulsed while a MULHI is in EXEC -> next cycle state IDLE, busy=0, alu_a/alu_b/alu_op=0, no rsp_valid ever asserted for it; a following simultaneous request is granted to port 0.
- Back-to-back TEST on port 0 with rsp0_ready=1 -> accepts every 3rd cycle, rsp_c equals a, rsp_zero=1 only for a=0.
